// File: rtl/seg7_pkg.sv
// seg7_pkg: segment pattern constants (index 0=a .. 6=g, 0=lit) and decoder FSM encoding
package seg7_pkg;
  localparam logic [0:6] SEG_0 = 7'b0000001;
  localparam logic [0:6] SEG_1 = 7'b1001111;
  localparam logic [0:6] SEG_2 = 7'b0010010;
  localparam logic [0:6] SEG_3 = 7'b0000110;
  localparam logic [0:6] SEG_4 = 7'b1001100;
  localparam logic [0:6] SEG_5 = 7'b0100100;
  localparam logic [0:6] SEG_6 = 7'b0100000;
  localparam logic [0:6] SEG_7 = 7'b0001111;
  localparam logic [0:6] SEG_8 = 7'b0000000;
  localparam logic [0:6] SEG_9 = 7'b0000100;
  localparam logic [0:6] SEG_A = 7'b0001000;
  localparam logic [0:6] SEG_B = 7'b1100000;
  localparam logic [0:6] SEG_C = 7'b0110001;
  localparam logic [0:6] SEG_D = 7'b1000010;
  localparam logic [0:6] SEG_E = 7'b0110000;
  localparam logic [0:6] SEG_F = 7'b0111000;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_MINUS = 7'b1111110;
  typedef enum logic {SETTLE = 1'b0, PENDING = 1'b1} state_t;
endpackage

// File: rtl/seg7_digit_decode.sv
// seg7_digit_decode: 7-seg pattern -> {invalid, minus, blank, value[3:0]}
// SEG7_HEX_DECODE_EN: when defined, A..F patterns decode to 4'hA..4'hF instead of invalid
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [0:6] seg_i,
  output logic [6:0] dec_o
);
  always_comb begin
    dec_o = {3'b100, 4'd0};
    case (seg_i)
      SEG_0:     dec_o = {3'b000, 4'd0};
      SEG_1:     dec_o = {3'b000, 4'd1};
      SEG_2:     dec_o = {3'b000, 4'd2};
      SEG_3:     dec_o = {3'b000, 4'd3};
      SEG_4:     dec_o = {3'b000, 4'd4};
      SEG_5:     dec_o = {3'b000, 4'd5};
      SEG_6:     dec_o = {3'b000, 4'd6};
      SEG_7:     dec_o = {3'b000, 4'd7};
      SEG_8:     dec_o = {3'b000, 4'd8};
      SEG_9:     dec_o = {3'b000, 4'd9};
      SEG_BLANK: dec_o = {3'b001, 4'd0};
      SEG_MINUS: dec_o = {3'b010, 4'd0};
`ifdef SEG7_HEX_DECODE_EN
      SEG_A:     dec_o = {3'b000, 4'hA};
      SEG_B:     dec_o = {3'b000, 4'hB};
      SEG_C:     dec_o = {3'b000, 4'hC};
      SEG_D:     dec_o = {3'b000, 4'hD};
      SEG_E:     dec_o = {3'b000, 4'hE};
      SEG_F:     dec_o = {3'b000, 4'hF};
`endif
      default:   dec_o = {3'b100, 4'd0};
    endcase
  end
endmodule

// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder: waits for a stable 4-digit 7-seg frame, decodes it and publishes it on valid/ready
// Hex digits A..F are decoded only when SEG7_HEX_DECODE_EN is defined (see seg7_digit_decode)
module seg7_frame_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:6] y0_i,
  input  logic [0:6] y1_i,
  input  logic [0:6] y2_i,
  input  logic [0:6] y3_i,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output logic [3:0] digit0_o,
  output logic [3:0] digit1_o,
  output logic [3:0] digit2_o,
  output logic [3:0] digit3_o,
  output logic [3:0] blank_o,
  output logic [3:0] minus_o,
  output logic [3:0] invalid_o,
  output logic       overrun_o
);
  logic [27:0] raw, sample_q, last_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pub_q, overrun_q, stable, new_frame;
  state_t state_q;
  logic [6:0] dec [4];
  logic [15:0] digits_q, digits_d;
  logic [3:0] blank_q, minus_q, invalid_q, blank_d, minus_d, invalid_d;
  assign raw = {y3_i, y2_i, y1_i, y0_i};
  for (genvar i = 0; i < 4; i++) begin : g_dec
    seg7_digit_decode u_dec (.seg_i(sample_q[7*i +: 7]), .dec_o(dec[i]));
    assign digits_d[4*i +: 4] = dec[i][3:0];
    assign blank_d[i]   = dec[i][4];
    assign minus_d[i]   = dec[i][5];
    assign invalid_d[i] = dec[i][6];
  end
  assign stable    = cnt_q == CNT_W'(STABLE_CYCLES);
  assign cnt_d     = (raw != sample_q) ? '0 : stable ? cnt_q : cnt_q + CNT_W'(1);
  // pub_q makes the first stable frame after reset count as new regardless of last_q
  assign new_frame = stable && (!pub_q || sample_q != last_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q  <= '1;
      cnt_q     <= '0;
      last_q    <= '0;
      pub_q     <= 1'b0;
      state_q   <= SETTLE;
      overrun_q <= 1'b0;
      digits_q  <= '0;
      blank_q   <= '0;
      minus_q   <= '0;
      invalid_q <= '0;
    end else begin
      sample_q <= raw;
      cnt_q    <= cnt_d;
      if (new_frame) begin
        last_q    <= sample_q;
        pub_q     <= 1'b1;
        state_q   <= PENDING;
        digits_q  <= digits_d;
        blank_q   <= blank_d;
        minus_q   <= minus_d;
        invalid_q <= invalid_d;
        if (state_q == PENDING && !out_ready_i) overrun_q <= 1'b1;
      end else if (state_q == PENDING && out_ready_i) begin
        state_q <= SETTLE;
      end
    end
  end
  assign out_valid_o = state_q == PENDING;
  assign digit0_o    = digits_q[3:0];
  assign digit1_o    = digits_q[7:4];
  assign digit2_o    = digits_q[11:8];
  assign digit3_o    = digits_q[15:12];
  assign blank_o     = blank_q;
  assign minus_o     = minus_q;
  assign invalid_o   = invalid_q;
  assign overrun_o   = overrun_q;
endmodule

// File: tb/tb_seg7_frame_decoder.sv
// tb_seg7_frame_decoder: directed scenarios plus randomized frames against a frame-level reference model
module tb_seg7_frame_decoder;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic [6:0] y0, y1, y2, y3;
  logic vld, ovr;
  logic [3:0] d0, d1, d2, d3, bl, mi, iv;
  int n_cmp = 0, n_err = 0;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b1111110;
  localparam logic [6:0] P [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
`ifdef SEG7_HEX_DECODE_EN
  localparam int NPAT = 16;
`else
  localparam int NPAT = 10;
`endif
  seg7_frame_decoder dut (
    .clk(clk), .rst(rst), .y0_i(y0), .y1_i(y1), .y2_i(y2), .y3_i(y3),
    .out_ready_i(rdy), .out_valid_o(vld),
    .digit0_o(d0), .digit1_o(d1), .digit2_o(d2), .digit3_o(d3),
    .blank_o(bl), .minus_o(mi), .invalid_o(iv), .overrun_o(ovr)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_frame(input logic [6:0] a3, a2, a1, a0);
    y3 = a3; y2 = a2; y1 = a1; y0 = a0;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!vld && n < 30) begin
      tick;
      n++;
    end
  endtask
  function automatic logic [6:0] dec(input logic [6:0] p);
    dec = {3'b100, 4'd0};
    if (p == BLANK) dec = {3'b001, 4'd0};
    else if (p == MINUS) dec = {3'b010, 4'd0};
    else for (int k = 0; k < NPAT; k++) if (p == P[k]) dec = {3'b000, 4'(k)};
  endfunction
  task automatic test_reset;
    rst = 1'b1; rdy = 1'b1;
    set_frame(BLANK, BLANK, BLANK, BLANK);
    tick; tick;
    n_cmp++;
    if ({vld, ovr, d3, d2, d1, d0, bl, mi, iv} !== 29'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h want 0", {vld, ovr, d3, d2, d1, d0, bl, mi, iv});
    end
    rst = 1'b0;
  endtask
  task automatic test_basic;
    int n, seen;
    set_frame(P[1], P[2], P[3], P[4]);
    wait_valid(n);
    n_cmp++;
    if (n !== 6) begin n_err++; $display("FAIL basic_latency: got %0d want 6", n); end
    n_cmp++;
    if ({d3, d2, d1, d0, bl, mi, iv} !== {16'h1234, 12'h000}) begin
      n_err++;
      $display("FAIL basic_data: got %h want %h", {d3, d2, d1, d0, bl, mi, iv}, {16'h1234, 12'h000});
    end
    seen = 0;
    repeat (10) begin tick; seen += int'(vld); end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL basic_single_pulse: extra valid cycles got %0d want 0", seen); end
  endtask
  task automatic test_glitch;
    int seen = 0;
    for (int i = 0; i < 32; i++) begin
      set_frame(P[1], P[2], P[3], ((i / 2) % 2) ? P[8] : P[0]);
      tick;
      seen += int'(vld);
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL glitch: valid cycles got %0d want 0", seen); end
  endtask
  task automatic test_overrun;
    int n;
    rdy = 1'b0;
    set_frame(P[5], P[5], P[5], P[5]);
    wait_valid(n);
    n_cmp++;
    if (n !== 6 || {d3, d2, d1, d0} !== 16'h5555) begin
      n_err++;
      $display("FAIL overrun_first: latency %0d digits %h want 6 5555", n, {d3, d2, d1, d0});
    end
    set_frame(P[6], P[6], P[6], P[6]);
    repeat (8) tick;
    n_cmp++;
    if ({vld, ovr, d3, d2, d1, d0} !== {2'b11, 16'h6666}) begin
      n_err++;
      $display("FAIL overrun_reload: got %h want %h", {vld, ovr, d3, d2, d1, d0}, {2'b11, 16'h6666});
    end
  endtask
  task automatic test_reset_mid;
    int n;
    rst = 1'b1;
    tick;
    n_cmp++;
    if ({vld, ovr, d3, d2, d1, d0} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_mid: got %h want 0", {vld, ovr, d3, d2, d1, d0});
    end
    rst = 1'b0;
    wait_valid(n);
    n_cmp++;
    if (n !== 6 || {ovr, d3, d2, d1, d0} !== {1'b0, 16'h6666}) begin
      n_err++;
      $display("FAIL reset_republish: latency %0d data %h want 6 %h", n, {ovr, d3, d2, d1, d0}, {1'b0, 16'h6666});
    end
    rdy = 1'b1;
    tick;
    n_cmp++;
    if (vld !== 1'b0) begin n_err++; $display("FAIL accept: valid got %b want 0", vld); end
  endtask
  task automatic test_flags;
    int n, seen;
    rdy = 1'b0;
    set_frame(BLANK, MINUS, P[9], 7'b0010011);
    wait_valid(n);
    n_cmp++;
    if ({bl, mi, iv, d3, d2, d1, d0} !== {4'b1000, 4'b0100, 4'b0001, 16'h0090}) begin
      n_err++;
      $display("FAIL flags: got %h want %h", {bl, mi, iv, d3, d2, d1, d0}, {4'b1000, 4'b0100, 4'b0001, 16'h0090});
    end
    rdy = 1'b1;
    tick;
    seen = 0;
    set_frame(P[8], P[8], P[8], P[8]);
    tick; tick;
    set_frame(BLANK, MINUS, P[9], 7'b0010011);
    repeat (15) begin tick; seen += int'(vld); end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL flags_repeat: valid cycles got %0d want 0", seen); end
  endtask
  task automatic test_hex;
    int n;
    rdy = 1'b0;
    set_frame(P[0], 7'b0001000, P[0], P[0]);
    wait_valid(n);
    n_cmp++;
`ifdef SEG7_HEX_DECODE_EN
    if (d2 !== 4'hA || iv !== 4'b0000) begin
      n_err++;
      $display("FAIL hex: digit2 %h invalid %b want a 0000", d2, iv);
    end
`else
    if (d2 !== 4'h0 || iv !== 4'b0100) begin
      n_err++;
      $display("FAIL hex: digit2 %h invalid %b want 0 0100", d2, iv);
    end
`endif
    rdy = 1'b1;
    tick;
  endtask
  task automatic test_random;
    logic [27:0] pool [3];
    logic [27:0] hist [$];
    logic [27:0] cur, last;
    logic [6:0] dd;
    logic [15:0] ed;
    logic [3:0] eb, em, ei;
    bit pub, pend, eovr, newf;
    int hold, r;
    for (int f = 0; f < 3; f++)
      for (int d = 0; d < 4; d++) begin
        r = $urandom_range(0, 19);
        pool[f][7*d +: 7] = r < 16 ? P[r] : r == 16 ? BLANK : r == 17 ? MINUS : 7'($urandom);
      end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    hist = '{28'hFFFFFFF};
    pub = 0; pend = 0; eovr = 0; last = '0; ed = '0; eb = '0; em = '0; ei = '0;
    for (int blk = 0; blk < 70; blk++) begin
      cur = pool[$urandom_range(0, 2)];
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        {y3, y2, y1, y0} = cur;
        rdy = 1'($urandom);
        // a frame is published once the last STABLE_CYCLES+1 samples agree and differ from the last published one
        newf = hist.size() >= 5;
        for (int k = 1; k <= 5 && newf; k++) newf = hist[hist.size() - k] == hist[hist.size() - 1];
        newf = newf && (!pub || hist[hist.size() - 1] != last);
        if (newf) begin
          last = hist[hist.size() - 1];
          if (pend && !rdy) eovr = 1;
          pub = 1; pend = 1;
          for (int d = 0; d < 4; d++) begin
            dd = dec(last[7*d +: 7]);
            ed[4*d +: 4] = dd[3:0];
            eb[d] = dd[4]; em[d] = dd[5]; ei[d] = dd[6];
          end
        end else if (pend && rdy) pend = 0;
        tick;
        hist.push_back(cur);
        if (hist.size() > 8) void'(hist.pop_front());
        n_cmp++;
        if ({vld, ovr, d3, d2, d1, d0, bl, mi, iv} !== {pend, eovr, ed, eb, em, ei}) begin
          n_err++;
          $display("FAIL random blk %0d: got %h want %h", blk, {vld, ovr, d3, d2, d1, d0, bl, mi, iv},
                   {pend, eovr, ed, eb, em, ei});
        end
      end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_overrun;
    test_reset_mid;
    test_flags;
    test_hex;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
